// File: rtl/msdf_abuf_writer_if.sv
// Stream + BRAM port-A bundle for the MSDF activation-buffer writer.
// slave = writer side, master = upstream / consumer / BRAM side.
interface msdf_abuf_writer_if #(
  parameter int NUM_LANES = 8,
  parameter int ADDR_W    = 9
);
  logic [NUM_LANES*3-1:0] dataInArray_0;
  logic                   pValidArray_0;
  logic                   readyArray_0;
  logic [ADDR_W-1:0]      a_buffer_addra;
  logic [NUM_LANES*3-1:0] a_buffer_dina;
  logic                   a_buffer_wea;
  logic                   frame_ready;
  logic                   frame_bank;
  logic                   frame_release;
  logic                   flush;

  modport slave (
    input  dataInArray_0, pValidArray_0, frame_release, flush,
    output readyArray_0, a_buffer_addra, a_buffer_dina, a_buffer_wea,
           frame_ready, frame_bank
  );

  modport master (
    output dataInArray_0, pValidArray_0, frame_release, flush,
    input  readyArray_0, a_buffer_addra, a_buffer_dina, a_buffer_wea,
           frame_ready, frame_bank
  );
endinterface

// File: rtl/msdf_abuf_writer.sv
// MSDF activation-buffer writer: sinks one digit word per transfer into
// BRAM port A, raises frame_ready once TARGET_PRECISION digits are resident
// and stalls until the consumer releases the frame.
// Optional build macro MSDF_ABUF_PINGPONG_EN: two banks (BASE_ADDR and
// BASE_ADDR+PP_OFFSET) so filling continues while one frame is being read.
module msdf_abuf_writer #(
  parameter int NUM_LANES        = 8,
  parameter int TARGET_PRECISION = 25,
  parameter int ADDR_W           = 9,
  parameter int BASE_ADDR        = 0,
  parameter int PP_OFFSET        = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  msdf_abuf_writer_if.slave      bus
);
  localparam int WORD_W = NUM_LANES * 3;
  localparam int IDX_W  = (TARGET_PRECISION > 1) ? $clog2(TARGET_PRECISION) : 1;
`ifdef MSDF_ABUF_PINGPONG_EN
  localparam int LAST_ADDR = BASE_ADDR + PP_OFFSET + TARGET_PRECISION - 1;
`else
  localparam int LAST_ADDR = BASE_ADDR + TARGET_PRECISION - 1;
`endif

  typedef enum logic {FILL, FULL} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din;
  } wrReq_t;

  state_t            state, stateNxt;
  logic [IDX_W-1:0]  digitIdx, idxNxt;
  logic              readyQ, readyNxt;
  wrReq_t            wrQ, wrNxt;
  logic              xfer, lastDigit;
  logic [ADDR_W-1:0] bankBase;

`ifdef MSDF_ABUF_PINGPONG_EN
  logic [1:0] full, fullNxt;
  logic       wrBank, wrBankNxt;
  logic       rdBank, rdBankNxt;
`else
  logic       frameQ, frameNxt;
`endif

  assign xfer      = bus.pValidArray_0 && readyQ;
  assign lastDigit = (digitIdx == IDX_W'(TARGET_PRECISION - 1));

`ifdef MSDF_ABUF_PINGPONG_EN
  assign bankBase = wrBank ? ADDR_W'(BASE_ADDR + PP_OFFSET) : ADDR_W'(BASE_ADDR);
`else
  assign bankBase = ADDR_W'(BASE_ADDR);
`endif

  // next-state: digit counter, write request, ready and frame flags
  always_comb begin
    stateNxt    = state;
    idxNxt      = digitIdx;
    readyNxt    = readyQ;
    wrNxt       = wrQ;
    wrNxt.we    = 1'b0;
`ifdef MSDF_ABUF_PINGPONG_EN
    fullNxt   = full;
    wrBankNxt = wrBank;
    rdBankNxt = rdBank;
    // release always targets the oldest full bank; banks complete in order
    if (bus.frame_release && |full) begin
      fullNxt[rdBank] = 1'b0;
      rdBankNxt       = ~rdBank;
    end
    if (bus.flush) begin
      // abandon only the partial fill; completed banks stay resident
      idxNxt = '0;
    end else if (xfer) begin
      wrNxt.we   = 1'b1;
      wrNxt.addr = bankBase + ADDR_W'(digitIdx);
      wrNxt.din  = bus.dataInArray_0;
      if (lastDigit) begin
        idxNxt          = '0;
        fullNxt[wrBank] = 1'b1;
        wrBankNxt       = ~wrBank;
      end else begin
        idxNxt = digitIdx + 1'b1;
      end
    end
    readyNxt = !fullNxt[wrBankNxt];
    stateNxt = readyNxt ? FILL : FULL;
`else
    frameNxt = frameQ;
    if (bus.flush) begin
      // flush beats everything, including a same-cycle transfer
      idxNxt   = '0;
      stateNxt = FILL;
      frameNxt = 1'b0;
      readyNxt = 1'b1;
    end else begin
      unique case (state)
        FILL: begin
          readyNxt = 1'b1;
          if (xfer) begin
            wrNxt.we   = 1'b1;
            wrNxt.addr = bankBase + ADDR_W'(digitIdx);
            wrNxt.din  = bus.dataInArray_0;
            if (lastDigit) begin
              // completing transfer wins over a same-cycle release
              idxNxt   = '0;
              frameNxt = 1'b1;
              readyNxt = 1'b0;
              stateNxt = FULL;
            end else begin
              idxNxt = digitIdx + 1'b1;
            end
          end
        end
        FULL: begin
          readyNxt = 1'b0;
          if (bus.frame_release) begin
            frameNxt = 1'b0;
            readyNxt = 1'b1;
            stateNxt = FILL;
          end
        end
        default: stateNxt = FILL;
      endcase
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      digitIdx <= '0;
      readyQ   <= 1'b0;
      wrQ      <= '0;
`ifdef MSDF_ABUF_PINGPONG_EN
      full     <= '0;
      wrBank   <= 1'b0;
      rdBank   <= 1'b0;
`else
      frameQ   <= 1'b0;
`endif
    end else begin
      state    <= stateNxt;
      digitIdx <= idxNxt;
      readyQ   <= readyNxt;
      wrQ      <= wrNxt;
`ifdef MSDF_ABUF_PINGPONG_EN
      full     <= fullNxt;
      wrBank   <= wrBankNxt;
      rdBank   <= rdBankNxt;
`else
      frameQ   <= frameNxt;
`endif
    end
  end

  assign bus.readyArray_0   = readyQ;
  assign bus.a_buffer_wea   = wrQ.we;
  assign bus.a_buffer_addra = wrQ.addr;
  assign bus.a_buffer_dina  = wrQ.din;
`ifdef MSDF_ABUF_PINGPONG_EN
  assign bus.frame_ready = |full;
  assign bus.frame_bank  = rdBank;
`else
  assign bus.frame_ready = frameQ;
  assign bus.frame_bank  = 1'b0;
`endif

`ifndef SYNTHESIS
  // the highest frame address must fit the BRAM address width
  always @(posedge clk) begin
    if (rst) assert (LAST_ADDR < (2 ** ADDR_W))
      else $error("msdf_abuf_writer: frame address %0d exceeds ADDR_W", LAST_ADDR);
  end
`endif
endmodule

// File: tb/tb_msdf_abuf_writer.sv
// Directed bench for msdf_abuf_writer; expected addresses/data hand-derived.
module tb_msdf_abuf_writer;
  localparam int NL = 8;
  localparam int AW = 9;
  localparam int TP = 25;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  msdf_abuf_writer_if #(.NUM_LANES(NL), .ADDR_W(AW)) bus ();

  msdf_abuf_writer #(
    .NUM_LANES(NL), .TARGET_PRECISION(TP), .ADDR_W(AW),
    .BASE_ADDR(0), .PP_OFFSET(256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // distinct 24-bit pattern per index (odd multiplier is a bijection mod 2^24)
  function automatic logic [NL*3-1:0] word(input int k);
    logic [31:0] v;
    v = (k * 32'h0001_0203) ^ 32'h005A_3C96;
    return v[NL*3-1:0];
  endfunction

  // one full clock: inputs driven at negedge are sampled at the next posedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_addra"}, 32'(bus.a_buffer_addra), 32'd0);
    chk({tag, "_dina"},  32'(bus.a_buffer_dina),  32'd0);
    chk({tag, "_wea"},   32'(bus.a_buffer_wea),   32'd0);
    chk({tag, "_rdy"},   32'(bus.readyArray_0),   32'd0);
    chk({tag, "_frdy"},  32'(bus.frame_ready),    32'd0);
    chk({tag, "_fbank"}, 32'(bus.frame_bank),     32'd0);
  endtask

  // one transfer-cycle write check
  task automatic chkWr(input string tag, input int addr, input int k);
    chk({tag, "_wea"},   32'(bus.a_buffer_wea),   32'd1);
    chk({tag, "_addra"}, 32'(bus.a_buffer_addra), 32'(addr));
    chk({tag, "_dina"},  32'(bus.a_buffer_dina),  32'(word(k)));
  endtask

  initial begin
    rst = 1'b0;
    bus.dataInArray_0 = '0;
    bus.pValidArray_0 = 1'b0;
    bus.frame_release = 1'b0;
    bus.flush         = 1'b0;
    #3;
    chkZero("reset");
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("rdy_after_reset", 32'(bus.readyArray_0), 32'd1);

`ifdef MSDF_ABUF_PINGPONG_EN
    // fill both banks back to back, then stall
    bus.pValidArray_0 = 1'b1;
    for (int k = 0; k < 2 * TP; k++) begin
      bus.dataInArray_0 = word(k);
      cyc();
      chkWr("pp_fill", (k < TP) ? k : 256 + k - TP, k);
    end
    chk("pp_stall_rdy",   32'(bus.readyArray_0), 32'd0);
    chk("pp_stall_frdy",  32'(bus.frame_ready),  32'd1);
    chk("pp_stall_fbank", 32'(bus.frame_bank),   32'd0);
    for (int k = 0; k < 10; k++) begin
      bus.dataInArray_0 = word(200 + k);
      cyc();
      chk("pp_stall_wea", 32'(bus.a_buffer_wea), 32'd0);
    end
    bus.frame_release = 1'b1;
    cyc();
    bus.frame_release = 1'b0;
    chk("pp_rel_rdy",   32'(bus.readyArray_0), 32'd1);
    chk("pp_rel_fbank", 32'(bus.frame_bank),   32'd1);
    chk("pp_rel_frdy",  32'(bus.frame_ready),  32'd1);
    chk("pp_rel_wea",   32'(bus.a_buffer_wea), 32'd0);
    for (int k = 0; k < TP; k++) begin
      bus.dataInArray_0 = word(300 + k);
      cyc();
      chkWr("pp_refill", k, 300 + k);
    end
    chk("pp_refill_rdy", 32'(bus.readyArray_0), 32'd0);
    bus.pValidArray_0 = 1'b0;
`else
    // full frame with pValid held high
    bus.pValidArray_0 = 1'b1;
    for (int k = 0; k < TP; k++) begin
      bus.dataInArray_0 = word(k);
      cyc();
      chkWr("frame", k, k);
      chk("frame_frdy", 32'(bus.frame_ready), (k == TP - 1) ? 32'd1 : 32'd0);
    end
    chk("full_rdy", 32'(bus.readyArray_0), 32'd0);
    for (int k = 0; k < 2; k++) begin
      bus.dataInArray_0 = word(50 + k);
      cyc();
      chk("full_wea",   32'(bus.a_buffer_wea),   32'd0);
      chk("full_addra", 32'(bus.a_buffer_addra), 32'd24);
      chk("full_rdy2",  32'(bus.readyArray_0),   32'd0);
      chk("full_frdy",  32'(bus.frame_ready),    32'd1);
    end

    // release
    bus.pValidArray_0 = 1'b0;
    bus.frame_release = 1'b1;
    cyc();
    bus.frame_release = 1'b0;
    chk("rel_frdy", 32'(bus.frame_ready),  32'd0);
    chk("rel_rdy",  32'(bus.readyArray_0), 32'd1);

    // bubbles until 10 digits written; release in FILL must do nothing
    begin
      int expIdx = 0;
      int c = 0;
      while (expIdx < 10) begin
        bus.pValidArray_0 = (c % 3 != 1);
        bus.frame_release = (c == 4);
        bus.dataInArray_0 = word(100 + c);
        cyc();
        if (c % 3 != 1) begin
          chkWr("bubble", expIdx, 100 + c);
          expIdx++;
        end else begin
          chk("bubble_idle", 32'(bus.a_buffer_wea), 32'd0);
        end
        c++;
      end
      bus.frame_release = 1'b0;
    end

    // flush with a same-cycle transfer: no write, next digit is 0
    bus.pValidArray_0 = 1'b1;
    bus.flush         = 1'b1;
    bus.dataInArray_0 = word(400);
    cyc();
    bus.flush = 1'b0;
    chk("flush_wea",  32'(bus.a_buffer_wea), 32'd0);
    chk("flush_frdy", 32'(bus.frame_ready),  32'd0);
    for (int k = 0; k < TP; k++) begin
      bus.dataInArray_0 = word(500 + k);
      bus.frame_release = (k == TP - 1);
      cyc();
      chkWr("postflush", k, 500 + k);
    end
    bus.frame_release = 1'b0;
    bus.pValidArray_0 = 1'b0;
    chk("relrace_frdy", 32'(bus.frame_ready),  32'd1);
    chk("relrace_rdy",  32'(bus.readyArray_0), 32'd0);
    cyc();
    chk("relrace_frdy2", 32'(bus.frame_ready), 32'd1);

    // flush in FULL acts as a release
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fullflush_frdy", 32'(bus.frame_ready),  32'd0);
    chk("fullflush_rdy",  32'(bus.readyArray_0), 32'd1);

    // reset at digit 12, away from any clock edge
    bus.pValidArray_0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.dataInArray_0 = word(600 + k);
      cyc();
      chkWr("premid", k, 600 + k);
    end
    bus.pValidArray_0 = 1'b0;
    #2 rst = 1'b0;
    #1 chkZero("midrst");
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("midrst_rdy", 32'(bus.readyArray_0), 32'd1);
    bus.pValidArray_0 = 1'b1;
    bus.dataInArray_0 = word(700);
    cyc();
    bus.pValidArray_0 = 1'b0;
    chkWr("midrst_first", 0, 700);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/msdf_abuf_writer.md
Name: msdf_abuf_writer

Overview:
- Elastic-stream sink that captures MSDF activation digits and writes them into the activation buffer BRAM through port A.
- It is the producer side of the buffer that the gradient stage reads through port B.
- Each accepted transfer carries one 3-bit signed digit per lane for all lanes and is written as one BRAM word.
- A frame is TARGET_PRECISION consecutive digits. The block signals when a frame is resident and waits for the consumer to release it.

Parameters:
NUM_LANES, 8, lanes per word (matches `NUM_GRADIENT); word width = NUM_LANES*3
TARGET_PRECISION, 25, digits per frame
ADDR_W, 9, BRAM address width
BASE_ADDR, 0, address of digit 0 of a frame
PP_OFFSET, 256, bank-1 base offset (ping-pong build only)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
dataInArray_0  in  NUM_LANES*3  digit word, lane i at [3i+2:3i]
pValidArray_0  in  1  upstream valid
readyArray_0  out  1  registered ready to upstream
a_buffer_addra  out  ADDR_W  BRAM port-A address
a_buffer_dina  out  NUM_LANES*3  BRAM port-A write data
a_buffer_wea  out  1  BRAM port-A write enable
frame_ready  out  1  a complete frame is resident
frame_bank  out  1  bank of the resident frame (0 in single-bank build)
frame_release  in  1  one-cycle pulse: consumer done with the resident frame
flush  in  1  synchronous abort of the frame being filled

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0: addra, dina, wea, readyArray_0, frame_ready, frame_bank.
  - digit_idx=0, state=FILL.
- First rising edge after rst returns to 1: readyArray_0 rises to 1.
- Handshake:
  - Transfer occurs when pValidArray_0 && readyArray_0 in the same cycle.
  - Data is sampled only on a transfer. pValid with ready=0 is held by upstream and ignored here.
- Write latency: 1 cycle. On the edge after a transfer, wea=1, addra=base+digit_idx, dina=sampled word. Otherwise wea=0; addra and dina hold their last values.
- States:
  - FILL: ready=1.
    - Each transfer increments digit_idx.
    - A transfer with digit_idx==TARGET_PRECISION-1 sets digit_idx=0, frame_ready=1, and readyArray_0=0 on the same edge, then moves to FULL.
    - The final write still issues on that edge.
  - FULL: ready=0, no writes. frame_release=1 sets frame_ready=0 and ready=1, then moves to FILL.
  - frame_release in FILL is ignored.
- flush:
  - Highest priority. A flush edge sets digit_idx=0 and state=FILL.
  - A transfer in the same cycle as flush is discarded (no write issued).
  - In FULL, flush also clears frame_ready, as if released.
- Simultaneous final transfer and frame_release in FILL: the transfer wins, state goes to FULL, and the release is ignored.
- Reset mid-frame: partial frame abandoned; next frame restarts at base+0.
- Address arithmetic: base+digit_idx computed in ADDR_W bits. Base+TARGET_PRECISION-1 must fit in ADDR_W; this is checked by a simulation-only assertion.

Optional Feature:
- Macro: MSDF_ABUF_PINGPONG_EN.
- Defined:
  - Two banks: bank 0 at BASE_ADDR, bank 1 at BASE_ADDR+PP_OFFSET.
  - Each bank has a full flag.
  - The writer fills bank wr_bank. On completion it sets that bank's full flag and toggles wr_bank.
  - ready=1 while the bank being written is not full. A stall occurs only when both banks are full.
  - frame_ready = OR of the full flags.
  - frame_bank = oldest full bank. frame_release clears that bank's flag.
  - flush clears only the partial fill; full banks are kept.
- Undefined: single bank at BASE_ADDR, frame_bank tied to 0, behaviour exactly as in Behaviour.

Test Plan:
- Reset then hold pValid=1 with 25 distinct words -> 25 writes at addra 0..24, one cycle after each transfer. frame_ready=1 on the edge of the final write. ready=0 from then on.
- Upstream bubbles (pValid toggling 1,0,1) -> writes only on transfer cycles, addresses contiguous, no duplicate or skipped digits.
- FULL then pulse frame_release -> frame_ready=0 and ready=1 next cycle. The next frame writes start again at addra 0.
- flush after 10 digits, simultaneous with a transfer -> no write that cycle. The next transfer writes addra 0. frame_ready stays 0.
- rst=0 asserted mid-frame (digit 12) -> all outputs 0 immediately, without waiting for a clock edge. After release, the next transfer writes addra 0.
- PINGPONG_EN, no releases, 60 digits offered -> bank 0 fills at 0..24 and bank 1 at 256..280, then ready=0. One frame_release with frame_bank=0 -> ready=1 and the writes refill 0..24.
